// File: rtl/spi_mcp4822_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_mcp4822_tx
// Description : SPI master that writes a stereo sample pair to an MCP4822
//               dual 12-bit DAC as two 16-bit command frames (A then B) and
//               pulses LDAC_n so both channels update together.
//               Optional macro SPI_DAC_SIGNED_IN_EN: samples arrive as two's
//               complement and are converted to offset binary at accept.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mcp4822_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int LDAC_W     = 4,
    parameter bit GAIN_1X    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] sample_a,
    input  logic [11:0] sample_b,
    input  logic        valid,
    output logic        ready,
    input  logic        shdn,
    output logic        busy,
    output logic        dac_cs_n,
    output logic        dac_sck,
    output logic        dac_mosi,
    output logic        dac_ldac_n
);

    localparam logic [15:0] c_DIV_LAST  = 16'(CLK_DIV - 1);
    // GAP state covers all but the last high cycle; LOAD_B supplies that one.
    localparam logic [15:0] c_GAP_LAST  = 16'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);
    // LATCH holds one lead-in cycle after cs_n rises, then LDAC_W low cycles.
    localparam logic [15:0] c_LDAC_LAST = 16'(LDAC_W);
`ifdef SPI_DAC_SIGNED_IN_EN
    localparam logic [11:0] c_SIGN_FLIP = 12'h800;
`else
    localparam logic [11:0] c_SIGN_FLIP = 12'h000;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_TAIL   = 3'd3,
        ST_GAP    = 3'd4,
        ST_LOAD_B = 3'd5,
        ST_LATCH  = 3'd6
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [3:0]  r_bit, w_bit_nxt;
    logic        r_phase, w_phase_nxt;     // 0: sck low half, 1: sck high half
    logic        r_is_b, w_is_b_nxt;       // frame currently being sent is B
    logic [11:0] r_data_a, r_data_b;
    logic        r_shdn;
    logic        r_ready, w_ready_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_cs_n, w_cs_n_nxt;
    logic        r_sck, w_sck_nxt;
    logic        r_mosi, w_mosi_nxt;
    logic        r_ldac_n, w_ldac_n_nxt;
    logic        w_load;
    logic [15:0] w_frame;
    logic [3:0]  w_bit_dn;

    assign w_frame  = {r_is_b, 1'b0, GAIN_1X, ~r_shdn, (r_is_b ? r_data_b : r_data_a)};
    assign w_bit_dn = r_bit - 4'd1;

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign dac_cs_n   = r_cs_n;
    assign dac_sck    = r_sck;
    assign dac_mosi   = r_mosi;
    assign dac_ldac_n = r_ldac_n;

    // State, counters, registered outputs and sample latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 16'd0;
            r_bit    <= 4'd0;
            r_phase  <= 1'b0;
            r_is_b   <= 1'b0;
            r_data_a <= 12'd0;
            r_data_b <= 12'd0;
            r_shdn   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_ldac_n <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_phase  <= w_phase_nxt;
            r_is_b   <= w_is_b_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_sck    <= w_sck_nxt;
            r_mosi   <= w_mosi_nxt;
            r_ldac_n <= w_ldac_n_nxt;
            if (w_load) begin
                r_data_a <= sample_a ^ c_SIGN_FLIP;
                r_data_b <= sample_b ^ c_SIGN_FLIP;
                r_shdn   <= shdn;
            end
        end
    end

    // Next-state sequencing and next values for every registered output.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_phase_nxt  = r_phase;
        w_is_b_nxt   = r_is_b;
        w_ready_nxt  = r_ready;
        w_busy_nxt   = r_busy;
        w_cs_n_nxt   = r_cs_n;
        w_sck_nxt    = r_sck;
        w_mosi_nxt   = r_mosi;
        w_ldac_n_nxt = r_ldac_n;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                w_cs_n_nxt = 1'b1;
                if (valid && r_ready) begin
                    w_load      = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_is_b_nxt  = 1'b0;
                    w_state_nxt = ST_LOAD_A;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                w_cs_n_nxt  = 1'b0;
                w_sck_nxt   = 1'b0;
                w_mosi_nxt  = w_frame[15];
                w_bit_nxt   = 4'd15;
                w_phase_nxt = 1'b0;
                w_cnt_nxt   = 16'd0;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_nxt = 16'd0;
                    if (!r_phase) begin
                        w_sck_nxt   = 1'b1;
                        w_phase_nxt = 1'b1;
                    end else begin
                        // Falling edge: the only place mosi moves mid-frame.
                        w_sck_nxt   = 1'b0;
                        w_phase_nxt = 1'b0;
                        if (r_bit == 4'd0) begin
                            w_mosi_nxt  = 1'b0;
                            w_state_nxt = ST_TAIL;
                        end else begin
                            w_bit_nxt  = w_bit_dn;
                            w_mosi_nxt = w_frame[w_bit_dn];
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_TAIL: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_nxt  = 16'd0;
                    w_cs_n_nxt = 1'b1;
                    if (r_is_b) begin
                        w_state_nxt = ST_LATCH;
                    end else begin
                        w_is_b_nxt  = 1'b1;
                        w_state_nxt = (GAP_CYCLES > 1) ? ST_GAP : ST_LOAD_B;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = ST_LOAD_B;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_LATCH: begin
                if (r_cnt == 16'd0) begin
                    w_ldac_n_nxt = 1'b0;
                end
                if (r_cnt == c_LDAC_LAST) begin
                    w_cnt_nxt    = 16'd0;
                    w_ldac_n_nxt = 1'b1;
                    w_ready_nxt  = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
